// File: rtl/alu_arbiter.sv
// Two-port arbiter that time-shares one combinational ALU: grant, issue, respond.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0,
  input  logic [3:0]        ctr0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  output logic              gnt0,

  input  logic              req1,
  input  logic [3:0]        ctr1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt1,

  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_ctr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero,

  output logic              rsp_valid0,
  output logic              rsp_valid1,
  output logic [DATA_W-1:0] rsp_res,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  logic [1:0] state_q, state_d;
  logic       port_q;
  logic       grant;
  logic       can_grant;
  logic       ctr_legal;
  logic       ctr_has_zero;

`ifdef ALU_ARBITER_RR_EN
  logic       last_gnt_q;
`endif

  // Reset gates the grant so a held request cannot be acknowledged while in reset.
  assign can_grant = rst_n && ((state_q == StIdle) || (state_q == StResp));

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (can_grant) begin
`ifdef ALU_ARBITER_RR_EN
      if (req0 && req1) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`else
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`endif
    end
  end

  assign grant = gnt0 | gnt1;

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = grant ? StIssue : StIdle;
      StIssue: state_d = StResp;
      StResp:  state_d = grant ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ctr_legal = 1'b0;
    case (alu_ctr)
      4'b0010, 4'b0110, 4'b0000, 4'b0001,
      4'b0111, 4'b1100, 4'b1111: ctr_legal = 1'b1;
      default:                   ctr_legal = 1'b0;
    endcase
  end

  // Only sub and bne produce a meaningful zero flag; others would leak a stale value.
  assign ctr_has_zero = (alu_ctr == 4'b0110) || (alu_ctr == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      port_q   <= 1'b0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_ctr  <= 4'b0000;
      rsp_res  <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q  <= gnt1;
        alu_ctr <= gnt1 ? ctr1 : ctr0;
        alu_in1 <= gnt1 ? a1 : a0;
        alu_in2 <= gnt1 ? b1 : b0;
      end
      if (state_q == StIssue) begin
        rsp_res  <= ctr_legal ? alu_res : '0;
        rsp_zero <= ctr_legal & ctr_has_zero & alu_zero;
        rsp_err  <= ~ctr_legal;
      end
    end
  end

`ifdef ALU_ARBITER_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
    end else if (grant) begin
      last_gnt_q <= gnt1;
    end
  end
`endif

  assign rsp_valid0 = (state_q == StResp) && !port_q;
  assign rsp_valid1 = (state_q == StResp) && port_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, the operand/result width, matching the shared ALU.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 The block SHALL have these requester-port signals, x = 0 or 1:
- req_x input 1: operation request, held until granted.
- ctr_x input 4: ALU control code.
- a_x, b_x input DATA_W: operands.
- gnt_x output 1: one-cycle acceptance pulse.
REQ-004 The block SHALL have these shared-ALU signals:
- alu_in1, alu_in2 output DATA_W: registered ALU operands.
- alu_ctr output 4: registered ALU control.
- alu_res input DATA_W, alu_zero input 1: ALU outputs.
REQ-005 The block SHALL have these response and status signals:
- rsp_valid0, rsp_valid1 output 1: one-cycle response strobes.
- rsp_res output DATA_W: result.
- rsp_zero output 1: zero flag.
- rsp_err output 1: illegal control code.
- busy output 1: operation in flight.

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE and RESP, with transitions IDLE->ISSUE on grant, ISSUE->RESP unconditionally, RESP->ISSUE on grant, and RESP->IDLE otherwise.
REQ-007 gnt_x SHALL be combinational, asserted only in IDLE or RESP, for at most one port per cycle, and only while req_x=1.
REQ-008 On the grant edge, the granted port's ctr/a/b SHALL be loaded into alu_ctr/alu_in1/alu_in2 and its port ID stored.
REQ-009 In ISSUE, alu_in1/alu_in2/alu_ctr SHALL remain stable, and on the ISSUE->RESP edge alu_res/alu_zero SHALL be captured.
REQ-010 In RESP, exactly one rsp_valid_x SHALL pulse, for the stored port ID, with rsp_res/rsp_zero/rsp_err valid in that cycle only.
REQ-011 Latency SHALL be 2 cycles from gnt_x to rsp_valid_x, and sustained throughput SHALL be one operation per 2 cycles.
REQ-012 rsp_zero SHALL equal the captured alu_zero for ctr 4'b0110 (sub) and 4'b1111 (bne), and SHALL be 0 for all other codes, masking the stale ALU zero flag.
REQ-013 Legal codes SHALL be 0010, 0110, 0000, 0001, 0111, 1100 and 1111.
REQ-014 For any other code, the request SHALL be granted and sequenced normally, but the response SHALL carry rsp_res=0, rsp_zero=0 and rsp_err=1.
REQ-015 busy SHALL be 1 in ISSUE and RESP, and 0 in IDLE.
REQ-016 If req_x drops before grant, the request SHALL be withdrawn with no response.
REQ-017 A port SHALL NOT be granted again before its previous response has pulsed, which follows by construction from REQ-006.
REQ-018 rsp_res/rsp_zero/rsp_err SHALL hold their values outside RESP, and SHALL be meaningful only while rsp_valid_x=1.

Reset
REQ-019 rst_n=0 SHALL asynchronously force the following:
- state=IDLE.
- gnt_x=0 and rsp_valid_x=0.
- alu_in1=0, alu_in2=0 and alu_ctr=4'b0000.
- rsp_res=0, rsp_zero=0, rsp_err=0 and busy=0.
- round-robin pointer=1, so port 0 wins first.
REQ-020 Reset asserted during ISSUE or RESP SHALL drop the in-flight operation with no response after release.
REQ-021 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-022 Macro ALU_ARBITER_RR_EN defined: simultaneous requests SHALL go to the port not most recently granted, with the pointer updated on every grant.
REQ-023 ALU_ARBITER_RR_EN undefined: port 0 SHALL have fixed priority, and port 1 SHALL be granted only when req0=0.

Verification
REQ-024 Reset, then req0 with ctr=0010, a=5, b=7 -> gnt0 in cycle 0, rsp_valid0 in cycle 2, rsp_res=12, rsp_zero=0, rsp_err=0.
REQ-025 req1 with ctr=0110, a=b=0x1234 -> rsp_res=0 and rsp_zero=1. Then req1 with ctr=0001, a=0, b=0 -> rsp_zero=0, proving the stale flag is masked.
REQ-026 req0 and req1 held together for 4 operations -> with RR_EN, grants alternate 0,1,0,1 with gnts 2 cycles apart. Without RR_EN, grants are 0,0,0,0 and port 1 is starved.
REQ-027 req0 with ctr=1010 -> rsp_valid0 with rsp_err=1, rsp_res=0 and rsp_zero=0, and the next legal operation has rsp_err=0.
REQ-028 rst_n pulsed low during ISSUE of an add -> no rsp_valid, all outputs reset, and a new request after release completes with the correct result.
